// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Next-PC source selected by decode/execute.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_e;

  // Fetch control states.
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } fetch_state_e;

  // True for the sources that carry a control-flow target.
  function automatic logic is_redirect(input pc_src_e src);
    return (src == PC_BRANCH) || (src == PC_JALR);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Signal bundle between the fetch stage and its neighbours
// (decode, execute, hazard unit, instruction memory).
interface pc_fetch_if #(
  parameter int DATA_WIDTH = 32
);

  // There is no valid/ready pair on this bundle: all inputs are sampled on
  // every rising edge, stall is the only back-pressure, and valid_id
  // qualifies the IF/ID contents (0 means the latch holds a bubble).

  // Control and redirect inputs.
  logic [1:0]            pc_src;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [DATA_WIDTH-1:0] pc_ex;
  logic                  stall;
  logic                  flush;
  logic                  halt_req;
  logic                  resume;

  // Instruction memory: address out, combinational read data in.
  logic [DATA_WIDTH-1:0] instr_in;
  logic [DATA_WIDTH-1:0] A;

  // IF/ID latch and status.
  logic [DATA_WIDTH-1:0] instr_id;
  logic [DATA_WIDTH-1:0] pc_id;
  logic [DATA_WIDTH-1:0] pc_plus4_id;
  logic                  valid_id;
  logic                  halted;
  logic                  misalign;

  // Fetch stage side.
  modport master (
    input  pc_src, imm_ext, alu_result, pc_ex, stall, flush, halt_req, resume,
    input  instr_in,
    output A, instr_id, pc_id, pc_plus4_id, valid_id, halted, misalign
  );

  // Surrounding pipeline / memory side.
  modport slave (
    output pc_src, imm_ext, alu_result, pc_ex, stall, flush, halt_req, resume,
    output instr_in,
    input  A, instr_id, pc_id, pc_plus4_id, valid_id, halted, misalign
  );

endinterface

// File: rtl/pc_fetch_pc_next_sel.sv
// Combinational next-PC mux: target arithmetic and redirect/stall/hold
// priority. Only meaningful while the fetch FSM is in RUN.
// Build option: PC_MISALIGN_TRAP_EN sends misaligned redirect targets to
// TRAP_VECTOR and raises trap_o; otherwise target bits [1:0] are cleared.
module pc_next_sel
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004
`endif
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  pc_src_e               pc_src_i,
  input  logic [DATA_WIDTH-1:0] imm_ext_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] pc_ex_i,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] pc_next_o,
  output logic                  redirect_o,
  output logic                  trap_o
);

  logic [DATA_WIDTH-1:0] target_raw;

  // Raw redirect target; both forms wrap modulo 2^DATA_WIDTH.
  always_comb begin
    target_raw = pc_ex_i + imm_ext_i;
    if (pc_src_i == PC_JALR) begin
      target_raw = alu_result_i & ~DATA_WIDTH'(1);
    end
  end

  // Priority: redirect > stall > hold > PC+4.
  always_comb begin
    pc_next_o  = pc_i;
    redirect_o = is_redirect(pc_src_i);
    trap_o     = 1'b0;
    if (redirect_o) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (target_raw[1:0] != 2'b00) begin
        trap_o    = 1'b1;
        pc_next_o = TRAP_VECTOR;
      end else begin
        pc_next_o = target_raw;
      end
`else
      pc_next_o = target_raw & ~DATA_WIDTH'(3);
`endif
    end else if (stall_i || (pc_src_i == PC_HOLD)) begin
      pc_next_o = pc_i;
    end else begin
      pc_next_o = pc_i + DATA_WIDTH'(4);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALT control and the
// IF/ID latch. Next-PC selection lives in pc_next_sel.
// Build option: PC_MISALIGN_TRAP_EN enables the misaligned-target trap
// (TRAP_VECTOR redirect, one-cycle misalign pulse, bubble in IF/ID).
module pc_fetch
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0004
`endif
) (
  input  logic         clk,
  input  logic         rst,
  pc_fetch_if.master   bus,
  output fetch_state_e dbg_state_o
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_id_q, pc_id_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic                  valid_q, valid_d;
  logic                  halted_q, halted_d;
  logic                  misalign_q, misalign_d;

  logic [DATA_WIDTH-1:0] pc_sel;
  logic                  redirect;
  logic                  trap;
  logic                  bubble;
  logic                  load;

  pc_next_sel #(
    .DATA_WIDTH (DATA_WIDTH)
`ifdef PC_MISALIGN_TRAP_EN
    , .TRAP_VECTOR(TRAP_VECTOR)
`endif
  ) u_pc_next_sel (
    .pc_i         (pc_q),
    .pc_src_i     (pc_src_e'(bus.pc_src)),
    .imm_ext_i    (bus.imm_ext),
    .alu_result_i (bus.alu_result),
    .pc_ex_i      (bus.pc_ex),
    .stall_i      (bus.stall),
    .pc_next_o    (pc_sel),
    .redirect_o   (redirect),
    .trap_o       (trap)
  );

  // Next state for FSM, PC and IF/ID. A halt request freezes the PC for
  // that cycle, so a redirect arriving together with halt_req is dropped.
  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    misalign_d = 1'b0;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_id_d    = pc_id_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    bubble     = 1'b0;
    load       = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        bubble  = 1'b1;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
          bubble   = 1'b1;
        end else begin
          pc_d       = pc_sel;
          misalign_d = trap;
          if (bus.flush || trap) begin
            bubble = 1'b1;
          end else if (!bus.stall) begin
            load = 1'b1;
          end
        end
      end
      HALT: begin
        bubble = 1'b1;
        if (bus.resume && !bus.halt_req) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d  = BOOT;
        halted_d = 1'b0;
        bubble   = 1'b1;
      end
    endcase

    if (bubble) begin
      instr_d = NOP_INSTR;
      pc_id_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = bus.instr_in;
      pc_id_d = pc_q;
      pc4_d   = pc_q + DATA_WIDTH'(4);
      valid_d = 1'b1;
    end
  end

  // FSM, PC and IF/ID registers; reset discards IF/ID immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      instr_q    <= NOP_INSTR;
      pc_id_q    <= '0;
      pc4_q      <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_id_q    <= pc_id_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.A           = pc_q;
  assign bus.instr_id    = instr_q;
  assign bus.pc_id       = pc_id_q;
  assign bus.pc_plus4_id = pc4_q;
  assign bus.valid_id    = valid_q;
  assign bus.halted      = halted_q;
  assign bus.misalign    = misalign_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios followed by a randomized run
// compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_pc_fetch;
  import riscv_pkg::*;

  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst;
  fetch_state_e dbg_state;

  pc_fetch_if #(.DATA_WIDTH(DW)) bus();

  pc_fetch #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // Instruction memory, 256 words, aliased over the address space.
  logic [31:0] mem [256];
  assign bus.instr_in = mem[bus.A[9:2]];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pc_id, m_pc4;
  logic        m_valid, m_halted, m_misalign;
  int          m_phase;  // 0 booting, 1 running, 2 halted

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pc_id = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_misalign = 1'b0; m_phase = 0;
  endtask

  task automatic model_bubble();
    m_instr = NOP; m_valid = 1'b0; m_pc_id = 32'h0; m_pc4 = 32'h0;
  endtask

  // Evaluates one rising edge from the inputs currently on the bus.
  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir, trap;
    m_misalign = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1;
      model_bubble();
    end else if (m_phase == 2) begin
      model_bubble();
      if (bus.resume && !bus.halt_req) m_phase = 1;
    end else if (bus.halt_req) begin
      m_phase = 2;
      model_bubble();
    end else begin
      redir = (bus.pc_src == 2'd1) || (bus.pc_src == 2'd2);
      tgt   = (bus.pc_src == 2'd1) ? bus.pc_ex + bus.imm_ext
                                   : {bus.alu_result[31:1], 1'b0};
      trap  = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      if (redir && tgt[1:0] != 2'b00) begin
        trap = 1'b1;
        tgt  = 32'h0000_0004;
      end
`else
      tgt[1:0] = 2'b00;
`endif
      m_misalign = trap;
      if (bus.flush || trap) begin
        model_bubble();
      end else if (!bus.stall) begin
        m_instr = mem[m_pc[9:2]];
        m_pc_id = m_pc;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
      end
      if (redir) m_pc = tgt;
      else if (!bus.stall && bus.pc_src != 2'd3) m_pc = m_pc + 32'd4;
    end
    m_halted = (m_phase == 2);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [1:0] src, input logic st, input logic fl,
                      input logic hr, input logic rs, input logic [31:0] imm,
                      input logic [31:0] alu, input logic [31:0] pex);
    bus.pc_src = src; bus.stall = st; bus.flush = fl;
    bus.halt_req = hr; bus.resume = rs;
    bus.imm_ext = imm; bus.alu_result = alu; bus.pc_ex = pex;
    #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step_inputs_zero();
    model_reset();
    #12;
    n_tests++; if (bus.A !== 32'h0) begin n_fail++; $display("FAIL reset_A: got %h required %h", bus.A, 32'h0); end
    n_tests++; if (bus.instr_id !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h required %h", bus.instr_id, NOP); end
    n_tests++; if (bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.valid_id); end
    n_tests++; if (bus.pc_id !== 32'h0 || bus.pc_plus4_id !== 32'h0) begin n_fail++; $display("FAIL reset_pcid: got %h/%h required 0/0", bus.pc_id, bus.pc_plus4_id); end
    n_tests++; if (bus.halted !== 1'b0 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b required 00", bus.halted, bus.misalign); end
    n_tests++; if (dbg_state !== BOOT) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg_state, BOOT); end
    #1 rst = 1'b0;
  endtask

  task automatic step_inputs_zero();
    bus.pc_src = 2'd0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.halt_req = 1'b0; bus.resume = 1'b0;
    bus.imm_ext = 32'h0; bus.alu_result = 32'h0; bus.pc_ex = 32'h0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_a, prev_a;
    logic        exp_v;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    prev_a = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idle();
      exp_a = exp_q.pop_front();
      exp_v = (i != 0);
      n_tests++; if (bus.A !== exp_a) begin n_fail++; $display("FAIL seq_A[%0d]: got %h required %h", i, bus.A, exp_a); end
      n_tests++; if (bus.valid_id !== exp_v) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b required %b", i, bus.valid_id, exp_v); end
      if (exp_v) begin
        n_tests++; if (bus.instr_id !== mem[prev_a[9:2]] || bus.pc_id !== prev_a) begin n_fail++; $display("FAIL seq_ifid[%0d]: got %h@%h required %h@%h", i, bus.instr_id, bus.pc_id, mem[prev_a[9:2]], prev_a); end
      end
      prev_a = exp_a;
    end
  endtask

  task automatic test_branch_flush();
    step(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h10);
    n_tests++; if (bus.A !== 32'h8) begin n_fail++; $display("FAIL branch_A: got %h required %h", bus.A, 32'h8); end
    n_tests++; if (bus.instr_id !== NOP || bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got %h/%b required %h/0", bus.instr_id, bus.valid_id, NOP); end
    idle();
    n_tests++; if (bus.A !== 32'hC || bus.valid_id !== 1'b1 || bus.instr_id !== mem[2] || bus.pc_plus4_id !== 32'hC) begin n_fail++; $display("FAIL branch_fetch: got A=%h v=%b i=%h p4=%h required A=c v=1 i=%h p4=c", bus.A, bus.valid_id, bus.instr_id, bus.pc_plus4_id, mem[2]); end
  endtask

  task automatic test_jalr();
    step(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h41, 32'h0);
    n_tests++; if (bus.A !== 32'h40 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_A: got %h/%b required 40/0", bus.A, bus.misalign); end
    step(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h42, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    n_tests++; if (bus.A !== 32'h4 || bus.misalign !== 1'b1 || bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL jalr_trap: got A=%h m=%b v=%b required A=4 m=1 v=0", bus.A, bus.misalign, bus.valid_id); end
    idle();
    n_tests++; if (bus.misalign !== 1'b0 || bus.A !== 32'h8) begin n_fail++; $display("FAIL trap_pulse: got m=%b A=%h required m=0 A=8", bus.misalign, bus.A); end
`else
    n_tests++; if (bus.A !== 32'h40 || bus.misalign !== 1'b0) begin n_fail++; $display("FAIL jalr_align: got A=%h m=%b required A=40 m=0", bus.A, bus.misalign); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] h_instr, h_pc;
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h20);
    h_instr = m_instr;
    h_pc    = m_pc_id;
    for (int i = 0; i < 3; i++) begin
      step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      n_tests++; if (bus.A !== 32'h20 || bus.instr_id !== h_instr || bus.pc_id !== h_pc) begin n_fail++; $display("FAIL stall_hold[%0d]: got A=%h i=%h p=%h required A=20 i=%h p=%h", i, bus.A, bus.instr_id, bus.pc_id, h_instr, h_pc); end
    end
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
    n_tests++; if (bus.A !== 32'h100 || bus.instr_id !== h_instr) begin n_fail++; $display("FAIL stall_redirect: got A=%h i=%h required A=100 i=%h", bus.A, bus.instr_id, h_instr); end
  endtask

  task automatic test_halt();
    step(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h30);
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    n_tests++; if (bus.halted !== 1'b1 || bus.A !== 32'h30 || bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got h=%b A=%h v=%b required h=1 A=30 v=0", bus.halted, bus.A, bus.valid_id); end
    idle();
    idle();
    n_tests++; if (bus.halted !== 1'b1 || bus.A !== 32'h30) begin n_fail++; $display("FAIL halt_hold: got h=%b A=%h required h=1 A=30", bus.halted, bus.A); end
    step(2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_wins: got h=%b required h=1", bus.halted); end
    step(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    n_tests++; if (bus.halted !== 1'b0 || bus.A !== 32'h30 || bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL resume: got h=%b A=%h v=%b required h=0 A=30 v=0", bus.halted, bus.A, bus.valid_id); end
    idle();
    n_tests++; if (bus.A !== 32'h34 || bus.pc_id !== 32'h30 || bus.valid_id !== 1'b1 || bus.instr_id !== mem[12]) begin n_fail++; $display("FAIL resume_fetch: got A=%h p=%h v=%b i=%h required A=34 p=30 v=1 i=%h", bus.A, bus.pc_id, bus.valid_id, bus.instr_id, mem[12]); end
  endtask

  task automatic test_async_reset();
    idle();
    idle();
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (bus.A !== 32'h0 || bus.valid_id !== 1'b0 || bus.instr_id !== NOP || bus.halted !== 1'b0) begin n_fail++; $display("FAIL async_reset: got A=%h v=%b i=%h h=%b required A=0 v=0 i=%h h=0", bus.A, bus.valid_id, bus.instr_id, bus.halted, NOP); end
    @(posedge clk);
    #3 rst = 1'b0;
    idle();
    n_tests++; if (bus.A !== 32'h0 || bus.valid_id !== 1'b0) begin n_fail++; $display("FAIL reboot: got A=%h v=%b required A=0 v=0", bus.A, bus.valid_id); end
    idle();
    n_tests++; if (bus.A !== 32'h4 || bus.valid_id !== 1'b1 || bus.instr_id !== mem[0]) begin n_fail++; $display("FAIL reboot_fetch: got A=%h v=%b i=%h required A=4 v=1 i=%h", bus.A, bus.valid_id, bus.instr_id, mem[0]); end
  endtask

  task automatic test_random();
    logic [1:0]  src;
    logic [31:0] imm, alu, pex;
    for (int i = 0; i < 400; i++) begin
      src = 2'($urandom_range(0, 3));
      imm = 32'($urandom_range(0, 511)) - 32'd256;
      alu = (i % 37 == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 1023));
      pex = ($urandom_range(0, 1) == 1) ? m_pc : 32'($urandom_range(0, 1023));
      if (i % 53 == 0) begin
        src = 2'd1; pex = 32'hFFFF_FFF8; imm = 32'h4;  // lands on 0xFFFFFFFC to exercise wrap
      end
      step(src, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0), imm, alu, pex);
      n_tests++; if (bus.A !== m_pc) begin n_fail++; $display("FAIL rand_A[%0d]: got %h required %h", i, bus.A, m_pc); end
      n_tests++; if (bus.valid_id !== m_valid || bus.instr_id !== m_instr) begin n_fail++; $display("FAIL rand_ifid[%0d]: got %h/%b required %h/%b", i, bus.instr_id, bus.valid_id, m_instr, m_valid); end
      if (m_valid) begin
        n_tests++; if (bus.pc_id !== m_pc_id || bus.pc_plus4_id !== m_pc4) begin n_fail++; $display("FAIL rand_pcid[%0d]: got %h/%h required %h/%h", i, bus.pc_id, bus.pc_plus4_id, m_pc_id, m_pc4); end
      end
      n_tests++; if (bus.halted !== m_halted || bus.misalign !== m_misalign) begin n_fail++; $display("FAIL rand_flags[%0d]: got h=%b m=%b required h=%b m=%b", i, bus.halted, bus.misalign, m_halted, m_misalign); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_branch_flush();
    test_jalr();
    test_stall();
    test_halt();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
